// File: rtl/traffic_pkg.sv
// Shared traffic-controller types: detector states, light bit map and detector defaults.
// Imported by the detector, its interface and the bench.
package traffic_pkg;

  typedef enum logic [2:0] {
    DET_IDLE    = 3'd0,
    DET_QUALIFY = 3'd1,
    DET_REQUEST = 3'd2,
    DET_SERVED  = 3'd3,
    DET_LOCKOUT = 3'd4
  } det_state_e;

  // Bit positions in the controller's 12-bit lights vector.
  typedef enum int {
    MR_R          = 0,
    MR_Y          = 1,
    MR_G          = 2,
    MR_GL         = 3,
    MR_GR         = 4,
    PED_MR_WALK   = 5,
    PED_CR_WALK   = 6,
    PED_DONT_WALK = 7,
    CR_R          = 8,
    CR_Y          = 9,
    CR_GL         = 10,
    CR_GR         = 11
  } light_idx_e;

  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_LOCKOUT     = 8;
  localparam int DEF_STUCK_LIMIT = 255;
  localparam int DEF_CNT_W       = 8;
  localparam int VEH_W           = 8;

endpackage

// File: rtl/cr_vehicle_detector_if.sv
// Sensor/controller side signals of the cross-road vehicle detector.
// The slave modport is the detector; the master modport is whoever drives the sensor and green level.
interface cr_vehicle_detector_if;
  logic                        loop_raw;
  logic                        cr_green;
  logic                        CR_vehicle_detect;
  logic                        sensor_fault;
  logic [traffic_pkg::VEH_W-1:0] veh_count;

  modport master (
    output loop_raw,
    output cr_green,
    input  CR_vehicle_detect,
    input  sensor_fault,
    input  veh_count
  );

  modport slave (
    input  loop_raw,
    input  cr_green,
    output CR_vehicle_detect,
    output sensor_fault,
    output veh_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; output lags the input by two edges.
// Both flops reset asynchronously to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/cr_vehicle_detector.sv
// Turns the raw cross-road loop sensor into a latched, debounced request with post-green lockout.
// Request rises DEBOUNCE+2 edges after the sensor goes high; a stuck-on sensor forces the request high.
module cr_vehicle_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int LOCKOUT     = DEF_LOCKOUT,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  cr_vehicle_detector_if.slave det_if
);
  logic             loop_s;
  logic             cr_green;
  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
  logic [VEH_W-1:0] veh_cnt_q, veh_cnt_d;
  logic             fault_q, fault_d;
  logic             detect_q, detect_d;
  logic             fsm_det_d;

  sync_2ff u_loop_sync (
    .clk (clk),
    .rst (rst),
    .d   (det_if.loop_raw),
    .q   (loop_s)
  );

  assign cr_green = det_if.cr_green;

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    lock_cnt_d = lock_cnt_q;
    veh_cnt_d  = veh_cnt_q;
    fsm_det_d  = 1'b0;
    case (state_q)
      DET_IDLE: begin
        if (loop_s && !cr_green) begin
          state_d   = DET_QUALIFY;
          deb_cnt_d = '0;
        end
      end
      DET_QUALIFY: begin
        if (!loop_s || cr_green) begin
          state_d = DET_IDLE;
        end else if (deb_cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          state_d   = DET_REQUEST;
          fsm_det_d = 1'b1;
          veh_cnt_d = veh_cnt_q + VEH_W'(1);
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      // The vehicle may have left the loop; the request stays latched until green.
      DET_REQUEST: begin
        if (cr_green) state_d = DET_SERVED;
        else          fsm_det_d = 1'b1;
      end
      DET_SERVED: begin
        if (!cr_green) begin
          state_d    = DET_LOCKOUT;
          lock_cnt_d = '0;
        end
      end
      DET_LOCKOUT: begin
        if (lock_cnt_q == CNT_W'(LOCKOUT - 1)) state_d = DET_IDLE;
        else                                   lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
      default: state_d = DET_IDLE;
    endcase
  end

  // Stuck detection runs regardless of the FSM and forces the request while flagged.
  always_comb begin
    stuck_cnt_d = '0;
    fault_d     = 1'b0;
    if (loop_s) begin
      stuck_cnt_d = (stuck_cnt_q == CNT_W'(STUCK_LIMIT)) ? stuck_cnt_q : stuck_cnt_q + CNT_W'(1);
      fault_d     = fault_q | (stuck_cnt_d == CNT_W'(STUCK_LIMIT));
    end
    detect_d = fsm_det_d | fault_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DET_IDLE;
      deb_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      stuck_cnt_q <= '0;
      veh_cnt_q   <= '0;
      fault_q     <= 1'b0;
      detect_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      veh_cnt_q   <= veh_cnt_d;
      fault_q     <= fault_d;
      detect_q    <= detect_d;
    end
  end

  assign det_if.CR_vehicle_detect = detect_q;
  assign det_if.sensor_fault      = fault_q;
  assign det_if.veh_count         = veh_cnt_q;
endmodule

// File: tb/tb_cr_vehicle_detector.sv
// Directed and random checks of the cross-road vehicle detector against a behavioural model.
module tb_cr_vehicle_detector;
  import traffic_pkg::*;

  localparam int DEB   = 4;
  localparam int LOCK  = 8;
  localparam int STUCK = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_raw = 1'b0;
  logic cr_green = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cr_vehicle_detector_if dif ();
  assign dif.loop_raw = loop_raw;
  assign dif.cr_green = cr_green;

  cr_vehicle_detector #(
    .DEBOUNCE    (DEB),
    .LOCKOUT     (LOCK),
    .STUCK_LIMIT (STUCK),
    .CNT_W       (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .det_if (dif)
  );

  always #5 clk = ~clk;

  // Reference model: sampled-sensor pipeline, run-length of high samples, and
  // request / waiting-for-green-off / lockout-remaining bookkeeping.
  bit m_s1, m_s2;
  int m_stuck;
  bit m_fault;
  int m_qual;
  bit m_req, m_served;
  int m_lock;
  int m_count;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_stuck = 0; m_fault = 0;
    m_qual = -1; m_req = 0; m_served = 0; m_lock = 0; m_count = 0;
  endtask

  task automatic model_edge();
    bit ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = loop_raw;
    m_stuck = ls ? ((m_stuck < STUCK) ? m_stuck + 1 : STUCK) : 0;
    m_fault = (m_stuck == STUCK);
    if (m_lock > 0) begin
      m_lock = m_lock - 1;
    end else if (m_served) begin
      if (!cr_green) begin m_served = 0; m_lock = LOCK; end
    end else if (m_req) begin
      if (cr_green) begin m_req = 0; m_served = 1; end
    end else if (m_qual >= 0) begin
      if (!ls || cr_green) m_qual = -1;
      else if (m_qual == DEB - 1) begin
        m_req = 1; m_qual = -1; m_count = (m_count + 1) % 256;
      end else m_qual = m_qual + 1;
    end else if (ls && !cr_green) begin
      m_qual = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs #1 later; returns at negedge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    chk({tag, "/det"},   32'(dif.CR_vehicle_detect), 32'(m_req | m_fault));
    chk({tag, "/fault"}, 32'(dif.sensor_fault),      32'(m_fault));
    chk({tag, "/count"}, 32'(dif.veh_count),         32'(m_count));
    @(negedge clk);
  endtask

  initial begin
    int start;
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_det",   32'(dif.CR_vehicle_detect), 0);
    chk("reset_fault", 32'(dif.sensor_fault),      0);
    chk("reset_count", 32'(dif.veh_count),         0);
    rst = 1'b0;

    // Test 1: get a request, reset asynchronously mid-cycle, then re-qualify from E0.
    loop_raw = 1'b1;
    for (int k = 0; k < 7; k++) step("t1_pre");
    chk("t1_pre_det", 32'(dif.CR_vehicle_detect), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_arst_det",   32'(dif.CR_vehicle_detect), 0);
    chk("t1_arst_count", 32'(dif.veh_count),         0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step("t1");
      if (k == 5) chk("t1_e5_det", 32'(dif.CR_vehicle_detect), 0);
    end
    chk("t1_e6_det",   32'(dif.CR_vehicle_detect), 1);
    chk("t1_e6_count", 32'(dif.veh_count),         1);
    loop_raw = 1'b0;

    // Test 3: request held until green, lockout ignores the loop, then a new request.
    repeat (10) step("t3_hold");
    chk("t3_held", 32'(dif.CR_vehicle_detect), 1);
    cr_green = 1'b1;
    step("t3_green");
    chk("t3_served", 32'(dif.CR_vehicle_detect), 0);
    repeat (4) step("t3_green");
    cr_green = 1'b0;
    step("t3_l0");
    loop_raw = 1'b1;
    repeat (5) step("t3_lock");
    loop_raw = 1'b0;
    repeat (10) step("t3_lock");
    chk("t3_lock_det",   32'(dif.CR_vehicle_detect), 0);
    chk("t3_lock_count", 32'(dif.veh_count),         1);
    loop_raw = 1'b1;
    repeat (7) step("t3_req2");
    chk("t3_req2_det",   32'(dif.CR_vehicle_detect), 1);
    chk("t3_req2_count", 32'(dif.veh_count),         2);
    loop_raw = 1'b0;
    cr_green = 1'b1;
    step("t3_clean");
    cr_green = 1'b0;
    repeat (12) step("t3_clean");

    // Test 2: a 3-sample blip never qualifies.
    loop_raw = 1'b1;
    repeat (3) step("t2");
    loop_raw = 1'b0;
    repeat (6) step("t2");
    chk("t2_det",   32'(dif.CR_vehicle_detect), 0);
    chk("t2_count", 32'(dif.veh_count),         2);

    // Test 5: cross road already green blocks qualification.
    cr_green = 1'b1;
    loop_raw = 1'b1;
    repeat (10) step("t5");
    chk("t5_det",   32'(dif.CR_vehicle_detect), 0);
    chk("t5_count", 32'(dif.veh_count),         2);
    loop_raw = 1'b0;
    repeat (3) step("t5");
    cr_green = 1'b0;
    repeat (2) step("t5");

    // Test 4: stuck-on sensor.
    loop_raw = 1'b1;
    for (int k = 0; k < 22; k++) begin
      step("t4");
      if (k == 20) chk("t4_e20_fault", 32'(dif.sensor_fault), 0);
    end
    chk("t4_fault", 32'(dif.sensor_fault),      1);
    chk("t4_det",   32'(dif.CR_vehicle_detect), 1);
    for (int p = 0; p < 3; p++) begin
      cr_green = 1'b1;
      repeat (3) step("t4_green");
      chk("t4_green_det", 32'(dif.CR_vehicle_detect), 1);
      cr_green = 1'b0;
      repeat (3) step("t4_red");
      chk("t4_red_det", 32'(dif.CR_vehicle_detect), 1);
    end
    loop_raw = 1'b0;
    n = 0;
    while (dif.sensor_fault && n < 3) begin
      step("t4_clear");
      n++;
    end
    chk("t4_clear_fault", 32'(dif.sensor_fault), 0);
    cr_green = 1'b1;
    repeat (2) step("t4_clean");
    cr_green = 1'b0;
    repeat (12) step("t4_clean");

    // Test 6: 256 request/serve rounds wrap the vehicle count.
    start = m_count;
    for (int i = 0; i < 256; i++) begin
      loop_raw = 1'b1;
      n = 0;
      while (!dif.CR_vehicle_detect && n < 20) begin
        step("t6_req");
        n++;
      end
      chk("t6_req_seen", 32'(dif.CR_vehicle_detect), 1);
      loop_raw = 1'b0;
      cr_green = 1'b1;
      step("t6_serve");
      cr_green = 1'b0;
      repeat (10) step("t6_lock");
      chk("t6_count", 32'(dif.veh_count), 32'((start + i + 1) % 256));
    end

    // Random sensor and green activity against the model.
    for (int r = 0; r < 3000; r++) begin
      if ($urandom_range(7) == 0)  loop_raw = ~loop_raw;
      if ($urandom_range(15) == 0) cr_green = ~cr_green;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
